// File: rtl/mem_stage_lsu_if.sv
// Bus bundle between the EX/MEM latch, DMEM, the MEM/WB latch and CP0 for the MEM-stage LSU.
// The LSU takes the slave view; the surrounding pipeline (or bench) takes the master view.
interface mem_stage_lsu_if;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        in_ready;
    logic        stall;
    logic        flush;
    logic        dm_ena;
    logic        dm_w;
    logic        dm_r;
    logic [3:0]  dm_byteena;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_badvaddr;
    logic        exc_ack;

    modport slave (
        input  in_valid, in_op, in_addr, in_wdata, in_rd, stall, flush, dm_rdata, exc_ack,
        output in_ready, dm_ena, dm_w, dm_r, dm_byteena, dm_addr, dm_wdata,
        output wb_valid, wb_rd, wb_data, exc_valid, exc_code, exc_badvaddr
    );

    modport master (
        output in_valid, in_op, in_addr, in_wdata, in_rd, stall, flush, dm_rdata, exc_ack,
        input  in_ready, dm_ena, dm_w, dm_r, dm_byteena, dm_addr, dm_wdata,
        input  wb_valid, wb_rd, wb_data, exc_valid, exc_code, exc_badvaddr
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: address translation, alignment/range check, DMEM drive,
// load extension into the MEM/WB latch, and a sticky AdEL/AdES state held until CP0 acks.
module mem_stage_lsu #(
    parameter logic [31:0] DATA_BASE = 32'h1001_0000,
    parameter int unsigned MEM_BYTES = 640
) (
    input logic            clk,
    input logic            rst_n,
    mem_stage_lsu_if.slave lsu
);

    typedef enum logic {StRun, StHold} state_e;

    state_e      state_q, state_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        exc_valid_q, exc_valid_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] exc_badvaddr_q, exc_badvaddr_d;

    logic        is_load, is_store, is_signed;
    logic [2:0]  size;
    logic [31:0] off;
    logic [32:0] end_off;
    logic        misalign, fault, go, access, load_done;
    logic [3:0]  byteena;
    logic [31:0] load_data;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_signed = 1'b0;
        size      = 3'd0;
        case (lsu.in_op)
            4'd1: begin is_load  = 1'b1; size = 3'd1; is_signed = 1'b1; end
            4'd2: begin is_load  = 1'b1; size = 3'd1; end
            4'd3: begin is_load  = 1'b1; size = 3'd2; is_signed = 1'b1; end
            4'd4: begin is_load  = 1'b1; size = 3'd2; end
            4'd5: begin is_load  = 1'b1; size = 3'd4; end
            4'd6: begin is_store = 1'b1; size = 3'd1; end
            4'd7: begin is_store = 1'b1; size = 3'd2; end
            4'd8: begin is_store = 1'b1; size = 3'd4; end
            default: ;
        endcase
    end

    // 33-bit end offset so an address below DATA_BASE (wrapped off) is out of range.
    assign off      = lsu.in_addr - DATA_BASE;
    assign end_off  = {1'b0, off} + {30'd0, size};
    assign misalign = ((size == 3'd2) & lsu.in_addr[0]) | ((size == 3'd4) & (|lsu.in_addr[1:0]));
    assign fault    = misalign | (end_off > 33'(MEM_BYTES));
    assign go       = lsu.in_valid & (is_load | is_store) & ~lsu.stall & ~lsu.flush &
                      (state_q == StRun);
    assign access    = go & ~fault;
    assign load_done = access & is_load;

    always_comb begin
        byteena = 4'b0000;
        if (is_store) begin
            case (size)
                3'd1:    byteena = 4'b0001;
                3'd2:    byteena = 4'b0011;
                default: byteena = 4'b1111;
            endcase
        end
    end

    always_comb begin
        case (size)
            3'd1:    load_data = {{24{is_signed & lsu.dm_rdata[7]}}, lsu.dm_rdata[7:0]};
            3'd2:    load_data = {{16{is_signed & lsu.dm_rdata[15]}}, lsu.dm_rdata[15:0]};
            default: load_data = lsu.dm_rdata;
        endcase
    end

    assign lsu.in_ready   = ~lsu.stall;
    assign lsu.dm_ena     = access;
    assign lsu.dm_r       = access & is_load;
    assign lsu.dm_w       = access & is_store;
    assign lsu.dm_byteena = access ? byteena : 4'b0000;
    assign lsu.dm_addr    = access ? off : 32'd0;
    assign lsu.dm_wdata   = access ? lsu.in_wdata : 32'd0;

    always_comb begin
        state_d        = state_q;
        exc_valid_d    = exc_valid_q;
        exc_code_d     = exc_code_q;
        exc_badvaddr_d = exc_badvaddr_q;
        wb_valid_d     = wb_valid_q;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;

        unique case (state_q)
            StRun: begin
                if (go && fault) begin
                    state_d        = StHold;
                    exc_valid_d    = 1'b1;
                    exc_code_d     = is_load ? 5'd4 : 5'd5;
                    exc_badvaddr_d = lsu.in_addr;
                end
            end
            StHold: begin
                if (lsu.exc_ack) begin
                    state_d     = StRun;
                    exc_valid_d = 1'b0;
                end
            end
            default: state_d = StRun;
        endcase

        // load_done already excludes stall, flush and HOLD.
        if (lsu.flush) begin
            wb_valid_d = 1'b0;
        end else if (!lsu.stall) begin
            wb_valid_d = load_done;
            if (load_done) begin
                wb_rd_d   = lsu.in_rd;
                wb_data_d = load_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StRun;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_data_q      <= 32'd0;
            exc_valid_q    <= 1'b0;
            exc_code_q     <= 5'd0;
            exc_badvaddr_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            exc_valid_q    <= exc_valid_d;
            exc_code_q     <= exc_code_d;
            exc_badvaddr_q <= exc_badvaddr_d;
        end
    end

    assign lsu.wb_valid     = wb_valid_q;
    assign lsu.wb_rd        = wb_rd_q;
    assign lsu.wb_data      = wb_data_q;
    assign lsu.exc_valid    = exc_valid_q;
    assign lsu.exc_code     = exc_code_q;
    assign lsu.exc_badvaddr = exc_badvaddr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed scenarios then random traffic, checked against a
// byte-array memory and an access-level model of the stage.
module tb_mem_stage_lsu;
    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam int          MEMB = 640;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_clr = 1'b1;
    int   errors = 0;
    int   checks = 0;

    mem_stage_lsu_if lsu ();

    mem_stage_lsu #(
        .DATA_BASE(BASE),
        .MEM_BYTES(MEMB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .lsu  (lsu)
    );

    always #5 clk = ~clk;

    logic [7:0] dmem    [MEMB];
    logic [7:0] ref_mem [MEMB];

    // DMEM stand-in: combinational read, write committed on negedge.
    always @(negedge clk) begin
        for (int i = 0; i < MEMB; i++) begin
            if (mem_clr) dmem[i] <= 8'h00;
        end
        if (!mem_clr && lsu.dm_w) begin
            for (int i = 0; i < 4; i++) begin
                if (lsu.dm_byteena[i] && (longint'(lsu.dm_addr) + i < MEMB))
                    dmem[int'(lsu.dm_addr) + i] <= lsu.dm_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        lsu.dm_rdata = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (longint'(lsu.dm_addr) + i < MEMB)
                lsu.dm_rdata[8*i +: 8] = dmem[int'(lsu.dm_addr) + i];
        end
    end

    // Reference state of the stage.
    bit          m_hold;
    logic [4:0]  m_code;
    logic [31:0] m_badv;
    bit          m_wbv;
    logic [4:0]  m_wbrd;
    logic [31:0] m_wbdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        chk("wb_valid", {31'd0, lsu.wb_valid}, {31'd0, m_wbv});
        chk("wb_rd", {27'd0, lsu.wb_rd}, {27'd0, m_wbrd});
        chk("wb_data", lsu.wb_data, m_wbdata);
        chk("exc_valid", {31'd0, lsu.exc_valid}, {31'd0, m_hold});
        chk("exc_code", {27'd0, lsu.exc_code}, {27'd0, m_code});
        chk("exc_badvaddr", lsu.exc_badvaddr, m_badv);
    endtask

    task automatic model_reset();
        m_hold = 0; m_code = 0; m_badv = 0; m_wbv = 0; m_wbrd = 0; m_wbdata = 0;
    endtask

    task automatic drive_idle();
        lsu.in_valid = 0; lsu.in_op = 0; lsu.in_addr = 0; lsu.in_wdata = 0; lsu.in_rd = 0;
        lsu.stall = 0; lsu.flush = 0; lsu.exc_ack = 0;
    endtask

    // One cycle: drive at posedge+1, check DMEM drive, advance model, check latches after edge.
    task automatic step(input logic v, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input logic st, input logic fl, input logic ack);
        int          size;
        bit          ld, sto, sgn, go, fault, ena;
        logic [31:0] off;
        longint      val;
        lsu.in_valid = v; lsu.in_op = op; lsu.in_addr = addr; lsu.in_wdata = wdata;
        lsu.in_rd = rd; lsu.stall = st; lsu.flush = fl; lsu.exc_ack = ack;
        #1;
        size = (op == 1 || op == 2 || op == 6) ? 1 :
               (op == 3 || op == 4 || op == 7) ? 2 :
               (op == 5 || op == 8) ? 4 : 0;
        ld  = (op >= 1 && op <= 5);
        sto = (op >= 6 && op <= 8);
        sgn = (op == 1 || op == 3);
        off = addr - BASE;
        go    = v && size != 0 && !st && !fl && !m_hold;
        fault = size != 0 && (((addr % size) != 0) || (longint'(off) + size > MEMB));
        ena   = go && !fault;
        chk("dm_ena", {31'd0, lsu.dm_ena}, {31'd0, ena});
        chk("dm_r", {31'd0, lsu.dm_r}, {31'd0, ena && ld});
        chk("dm_w", {31'd0, lsu.dm_w}, {31'd0, ena && sto});
        chk("dm_byteena", {28'd0, lsu.dm_byteena}, (ena && sto) ? 32'((1 << size) - 1) : 32'd0);
        chk("dm_addr", lsu.dm_addr, ena ? off : 32'd0);
        chk("dm_wdata", lsu.dm_wdata, ena ? wdata : 32'd0);
        chk("in_ready", {31'd0, lsu.in_ready}, {31'd0, !st});

        if (ena && sto)
            for (int i = 0; i < size; i++) ref_mem[int'(off) + i] = wdata[8*i +: 8];
        val = 0;
        if (ena && ld) begin
            for (int i = 0; i < size; i++) val += longint'(ref_mem[int'(off) + i]) << (8 * i);
            if (sgn && val >= (longint'(1) << (8 * size - 1))) val -= longint'(1) << (8 * size);
        end

        if (m_hold) begin
            if (ack) m_hold = 0;
        end else if (go && fault) begin
            m_hold = 1;
            m_code = ld ? 5'd4 : 5'd5;
            m_badv = addr;
        end
        if (fl) m_wbv = 0;
        else if (!st) begin
            m_wbv = ena && ld;
            if (ena && ld) begin
                m_wbrd = rd;
                m_wbdata = 32'(val);
            end
        end

        @(posedge clk);
        #1;
        check_regs();
    endtask

    initial begin
        int     ndiff;
        int     r;
        logic [31:0] a;
        drive_idle();
        model_reset();
        for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        mem_clr = 0;
        check_regs();
        chk("reset_dm_ena", {31'd0, lsu.dm_ena}, 32'd0);
        chk("reset_dm_addr", lsu.dm_addr, 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        step(1, 8, BASE, 32'h8081_7F80, 5'd0, 0, 0, 0);
        step(1, 1, BASE, 0, 5'd3, 0, 0, 0);
        chk("lb_00", lsu.wb_data, 32'hFFFF_FF80);
        step(1, 1, BASE + 1, 0, 5'd4, 0, 0, 0);
        chk("lb_01", lsu.wb_data, 32'h0000_007F);
        step(1, 4, BASE + 2, 0, 5'd5, 0, 0, 0);
        chk("lhu_02", lsu.wb_data, 32'h0000_8081);
        step(1, 3, BASE + 2, 0, 5'd6, 0, 0, 1);
        chk("lh_02", lsu.wb_data, 32'hFFFF_8081);
        step(1, 5, BASE, 0, 5'd7, 0, 0, 0);
        chk("lw_00", lsu.wb_data, 32'h8081_7F80);
        chk("lw_00_rd", {27'd0, lsu.wb_rd}, 32'd7);

        step(1, 5, BASE + 2, 0, 5'd8, 0, 0, 0);
        chk("adel_valid", {31'd0, lsu.exc_valid}, 32'd1);
        chk("adel_code", {27'd0, lsu.exc_code}, 32'd4);
        chk("adel_badv", lsu.exc_badvaddr, 32'h1001_0002);
        chk("adel_wbv", {31'd0, lsu.wb_valid}, 32'd0);
        step(1, 8, BASE, 32'hDEAD_BEEF, 5'd0, 0, 0, 0);
        step(1, 5, BASE, 0, 5'd9, 0, 0, 1);
        chk("ack_clear", {31'd0, lsu.exc_valid}, 32'd0);
        chk("ack_discard", {31'd0, lsu.wb_valid}, 32'd0);
        step(1, 5, BASE, 0, 5'd10, 0, 0, 0);
        chk("lw_after_hold", lsu.wb_data, 32'h8081_7F80);

        step(1, 7, BASE + 5, 32'h1234, 5'd0, 0, 0, 0);
        chk("ades_code", {27'd0, lsu.exc_code}, 32'd5);
        step(0, 0, 0, 0, 5'd0, 0, 0, 1);
        step(1, 5, BASE + 32'h27E, 0, 5'd11, 0, 0, 0);
        chk("range_code", {27'd0, lsu.exc_code}, 32'd4);
        step(0, 0, 0, 0, 5'd0, 0, 0, 1);
        step(1, 2, BASE + 32'h27F, 0, 5'd12, 0, 0, 0);
        chk("last_byte_ok", {31'd0, lsu.wb_valid}, 32'd1);
        step(1, 5, BASE - 4, 0, 5'd13, 0, 0, 0);
        chk("below_base", {31'd0, lsu.exc_valid}, 32'd1);
        step(0, 0, 0, 0, 5'd0, 0, 0, 1);

        step(1, 5, BASE, 0, 5'd14, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 1, BASE + 1, 0, 5'd15, 1, 0, 0);
        chk("stall_hold", lsu.wb_data, 32'h8081_7F80);
        step(1, 1, BASE + 1, 0, 5'd15, 1, 1, 0);
        chk("flush_stall", {31'd0, lsu.wb_valid}, 32'd0);

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            a = (r == 0) ? 32'($urandom) : BASE + $urandom_range(0, 660);
            step($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)), a, 32'($urandom),
                 5'($urandom_range(0, 31)), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
        end

        if (!m_hold) step(1, 5, BASE + 1, 0, 5'd1, 0, 0, 0);
        drive_idle();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_regs();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        step(1, 2, BASE, 0, 5'd2, 0, 0, 0);
        chk("lbu_after_reset", {31'd0, lsu.wb_valid}, 32'd1);

        ndiff = 0;
        for (int i = 0; i < MEMB; i++) if (dmem[i] !== ref_mem[i]) ndiff++;
        chk("mem_contents", 32'(ndiff), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
